pad_in_conditioner: RTL and testbench

Core-side receiver for a bidirectional pad: takes the raw value returned by the pad cell's input buffer, synchronizes it into the system clock domain, debounces it with a programmable stable-time filter, and publishes a clean level plus single-cycle rise and fall event pulses. It also owns the pad's input-enable attribute bit, sequencing it on and off with a warm-up period so that the core never sees a value from a disabled or settling input buffer. It sits between the pad ring and GPIO or interrupt logic, one instance per conditioned input pad.

---
 rtl/pad_in_pkg.sv | 15 +
 rtl/pad_in_sync.sv | 24 ++
 rtl/pad_in_conditioner.sv | 139 +++++++++++++
 tb/tb_pad_in_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pad_in_pkg.sv
// Shared types for the pad input conditioner: FSM state encoding and the
// pad attribute vector bit position owned by this block.
package pad_in_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    STABLE  = 2'd2,
    PENDING = 2'd3
  } state_t;

  // Position of the input-enable bit inside the pad cell attribute vector.
  localparam int PAD_ATTR_IE_BIT = 2;

endpackage

// File: rtl/pad_in_sync.sv
// Reset-to-zero flop chain bringing the asynchronous pad value into clk_i.
// This is the only flop set that samples the raw pad input.
module pad_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pad_in_conditioner.sv
// Pad receiver: synchronize, debounce with a programmable stable time, and
// publish a clean level with rise/fall pulses; also sequences the pad IE bit.
module pad_in_conditioner
  import pad_in_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int WARMUP_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
  input  logic             pad_c_i,
  output logic             pad_ie_o,
  output logic             valid_o,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output state_t           state_o
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic s;

  pad_in_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pad_c_i),
    .q_o   (s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pad_ie_q, pad_ie_d;
  logic             valid_q, valid_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // valid_o is a level qualifier, not a handshake: while high, level_o and the
  // edge pulses come from samples taken after the input buffer has settled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    if (!en_i) begin
      // Dropping enable discards any pending transition; level_o is held.
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WARMUP;
          cnt_d   = '0;
        end
        WARMUP: begin
          if (cnt_q == WARM_LAST) begin
            // Initial load is never reported as an edge.
            state_d = STABLE;
            level_d = s;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STABLE: begin
          if (s != level_q) begin
            if (debounce_cycles_i == '0) begin
              level_d = s;
              rise_d  = s;
              fall_d  = ~s;
            end else begin
              state_d = PENDING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (s == level_q) begin
            state_d = STABLE;
          end else if (cnt_q >= debounce_cycles_i) begin
            state_d = STABLE;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    pad_ie_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pad_ie_q <= 1'b0;
      valid_q  <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pad_ie_q <= pad_ie_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign pad_ie_o = pad_ie_q;
  assign valid_o  = valid_q;
  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_pad_in_conditioner.sv
// Directed bench for pad_in_conditioner: warm-up, debounce accept/reject,
// N=0 toggling, disable mid-pending, live N change and reset mid-pending.
module tb_pad_in_conditioner;
  import pad_in_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] n;
  logic             pad;
  logic             pad_ie, valid, level, rise, fall;
  state_t           state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pad_in_conditioner #(
    .SYNC_STAGES   (2),
    .WARMUP_CYCLES (4),
    .CNT_W         (CNT_W)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .en_i              (en),
    .debounce_cycles_i (n),
    .pad_c_i           (pad),
    .pad_ie_o          (pad_ie),
    .valid_o           (valid),
    .level_o           (level),
    .rise_o            (rise),
    .fall_o            (fall),
    .state_o           (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pad = 1'b1; n = '0;
    tick(); tick();
    check("rst_pad_ie", 32'(pad_ie), 0);
    check("rst_valid",  32'(valid),  0);
    check("rst_level",  32'(level),  0);
    check("rst_rise",   32'(rise),   0);
    check("rst_fall",   32'(fall),   0);
    check("rst_state",  32'(state),  32'(IDLE));

    // enable with pad=1, defaults
    rst = 1'b0; en = 1'b1;
    tick();
    check("en_pad_ie", 32'(pad_ie), 1);
    check("en_state",  32'(state),  32'(WARMUP));
    check("en_valid",  32'(valid),  0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("warm_valid", 32'(valid), 0);
      check("warm_rise",  32'(rise),  0);
    end
    tick();
    check("warm_done_valid", 32'(valid), 1);
    check("warm_done_level", 32'(level), 1);
    check("warm_done_rise",  32'(rise),  0);
    check("warm_done_state", 32'(state), 32'(STABLE));

    // N=3: accepted fall at edge 6
    n = 16'd3; pad = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("n3_fall_wait_level", 32'(level), 1);
      check("n3_fall_wait_pulse", 32'(fall),  0);
      if (i == 3) check("n3_pending", 32'(state), 32'(PENDING));
    end
    tick();
    check("n3_fall_level", 32'(level), 0);
    check("n3_fall_pulse", 32'(fall),  1);
    check("n3_fall_state", 32'(state), 32'(STABLE));
    tick();
    check("n3_fall_once", 32'(fall), 0);

    // N=3: accepted rise at edge 6
    pad = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("n3_rise_wait_level", 32'(level), 0);
      check("n3_rise_wait_pulse", 32'(rise),  0);
    end
    tick();
    check("n3_rise_level", 32'(level), 1);
    check("n3_rise_pulse", 32'(rise),  1);
    tick();
    check("n3_rise_once",  32'(rise),  0);
    check("n3_rise_hold",  32'(level), 1);

    // N=3: 3-cycle glitch rejected
    pad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) pad = 1'b1;
      tick();
      check("glitch_level", 32'(level), 1);
      check("glitch_fall",  32'(fall),  0);
      if (k == 5) check("glitch_pending", 32'(state), 32'(PENDING));
    end
    check("glitch_state", 32'(state), 32'(STABLE));

    // N=0: toggling pad, each sample through after 3 edges
    n = '0;
    for (int k = 1; k <= 8; k++) begin
      pad = (k <= 4) ? ((k % 2) == 0) : 1'b1;
      tick();
      check("n0_rise",  32'(rise),  32'((k == 4) || (k == 6)));
      check("n0_fall",  32'(fall),  32'((k == 3) || (k == 5)));
      check("n0_level", 32'(level), 32'(!((k == 3) || (k == 5))));
    end

    // N=5: disable two cycles into PENDING
    n = 16'd5; pad = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("dis_wait_fall", 32'(fall), 0);
    end
    check("dis_pending", 32'(state), 32'(PENDING));
    en = 1'b0;
    tick();
    check("dis_state",  32'(state),  32'(IDLE));
    check("dis_pad_ie", 32'(pad_ie), 0);
    check("dis_valid",  32'(valid),  0);
    check("dis_level",  32'(level),  1);
    check("dis_fall",   32'(fall),   0);
    tick(); tick();
    check("dis_hold_level", 32'(level), 1);
    check("dis_hold_fall",  32'(fall),  0);
    en = 1'b1;
    tick();
    check("reen_pad_ie", 32'(pad_ie), 1);
    check("reen_state",  32'(state),  32'(WARMUP));
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("reen_valid", 32'(valid), 0);
      check("reen_level", 32'(level), 1);
      check("reen_fall",  32'(fall),  0);
    end
    tick();
    check("reen_done_valid", 32'(valid), 1);
    check("reen_done_level", 32'(level), 0);
    check("reen_done_fall",  32'(fall),  0);
    check("reen_done_rise",  32'(rise),  0);
    check("reen_done_state", 32'(state), 32'(STABLE));

    // N lowered live during PENDING
    pad = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("live_wait_level", 32'(level), 0);
      check("live_wait_rise",  32'(rise),  0);
    end
    n = 16'd1;
    tick();
    check("live_level", 32'(level), 1);
    check("live_rise",  32'(rise),  1);

    // reset mid-PENDING with level=1 and en held high
    n = 16'd5; pad = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("rstp_pending", 32'(state), 32'(PENDING));
    rst = 1'b1;
    tick();
    check("rstp_pad_ie", 32'(pad_ie), 0);
    check("rstp_valid",  32'(valid),  0);
    check("rstp_level",  32'(level),  0);
    check("rstp_rise",   32'(rise),   0);
    check("rstp_fall",   32'(fall),   0);
    check("rstp_state",  32'(state),  32'(IDLE));
    tick();
    check("rstp_hold_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    tick();
    check("rstp_rel_state",  32'(state),  32'(WARMUP));
    check("rstp_rel_pad_ie", 32'(pad_ie), 1);
    check("rstp_rel_valid",  32'(valid),  0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
